stamofu_req_arbiter: RTL and testbench
======================================

STAMOFU_REQ_ARBITER -- requirements
Module: stamofu_req_arbiter

Interface
REQ-001 Parameter: STARVE_THRESHOLD, 4, consecutive pipe-loss cycles before pipe is forced to win (range 1..15).
REQ-002 Parameter: LOG_STAMOFU_MQ_ENTRIES, 3, width of misaligned-queue index.
REQ-003 CLK  in  1  clock; single rising-edge domain.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 pipe_REQ_valid/is_store/is_amo/is_fence/op/is_mq/misaligned/misaligned_exception/VPN/PO_word/byte_mask/write_data/cq_index  in  1/1/1/1/4/1/1/1/VPN_WIDTH/PO_WIDTH-2/4/32/LOG_STAMOFU_CQ_ENTRIES  request from stamofu address pipeline REQ stage.
REQ-006 pipe_REQ_ack  out  1  pipe request accepted this cycle.
REQ-007 mq_REQ_valid plus the same field set as REQ-005, plus mq_REQ_mq_index  in  LOG_STAMOFU_MQ_ENTRIES  request from misaligned queue.
REQ-008 mq_REQ_ack  out  1  MQ request accepted this cycle.
REQ-009 out_valid plus the REQ-005 field set, plus out_from_mq (1) and out_mq_index (LOG_STAMOFU_MQ_ENTRIES)  out  registered request toward dtlb/dcache.
REQ-010 out_ready  in  1  downstream consumes out_* this cycle when out_valid=1.

Function
REQ-011 One output register slot; slot is free when out_valid=0 or out_ready=1 (free = !out_valid | out_ready).
REQ-012 Grant is combinational; at most one of pipe_REQ_ack, mq_REQ_ack is high per cycle.
REQ-013 ack = requester valid & granted & free; an ack is never asserted without the matching valid.
REQ-014 A request acked in cycle N SHALL appear on out_* in cycle N+1 with out_valid=1; fields are copied bit-exact.
REQ-015 For a pipe win: out_from_mq=0 and out_mq_index=0. For an MQ win: out_from_mq=1 and out_mq_index=mq_REQ_mq_index.
REQ-016 If free and no request is granted, out_valid SHALL go to 0 next cycle; out fields SHALL hold their last values.
REQ-017 If not free, out_* SHALL hold and no ack is given.
REQ-018 Default priority: MQ over pipe, because MQ holds older second halves.
REQ-019 FSM states: NORMAL and PIPE_FORCE. In PIPE_FORCE, pipe wins if pipe_REQ_valid; otherwise MQ may win.
REQ-020 starve_cnt (4-bit, saturating at 15): increments when pipe_REQ_valid & !pipe_REQ_ack & mq_REQ_ack; clears on pipe_REQ_ack or when pipe_REQ_valid=0.
REQ-021 NORMAL->PIPE_FORCE when starve_cnt reaches STARVE_THRESHOLD. PIPE_FORCE->NORMAL on pipe_REQ_ack or pipe_REQ_valid=0; starve_cnt clears on that transition.
REQ-022 Backpressure cycles (not free) SHALL NOT change starve_cnt or the FSM state.

Reset
REQ-023 nRST low asynchronously forces: out_valid=0, all out fields=0 except out_byte_mask=4'b1111, starve_cnt=0, FSM=NORMAL.
REQ-024 While nRST is low, both acks SHALL be 0.
REQ-025 Reset mid-transfer drops the held request; no replay.

Configuration
REQ-026 Macro STAMOFU_REQ_ARBITER_STARVE_EN defined: REQ-019 to REQ-022 are active.
REQ-027 Macro STAMOFU_REQ_ARBITER_STARVE_EN undefined: fixed MQ priority; no FSM and no counter are synthesized; STARVE_THRESHOLD is ignored.

Verification
REQ-028 Single request: pipe_REQ_valid=1, cq_index=5, VPN=0x12345, out_ready=1 -> pipe_REQ_ack=1 in cycle N; cycle N+1 out_valid=1, out_cq_index=5, out_VPN=0x12345, out_from_mq=0.
REQ-029 Contention: pipe and MQ both valid, mq_index=2, starve_cnt=0 -> mq_REQ_ack=1, pipe_REQ_ack=0; next cycle out_from_mq=1, out_mq_index=2.
REQ-030 Starvation (STARVE_EN, threshold 4): pipe and MQ held valid, out_ready=1 -> MQ wins 4 cycles, pipe wins the 5th, then FSM returns to NORMAL. Without the macro, MQ wins every cycle.
REQ-031 Backpressure: out_valid=1, out_ready=0 for 3 cycles with both requesters valid -> no acks, out_* stable, starve_cnt unchanged; out_ready=1 -> MQ acked the same cycle.
REQ-032 Reset mid-op: out_valid=1, starve_cnt=3, nRST pulsed low between clock edges -> immediately out_valid=0, out_byte_mask=4'b1111, acks=0; after release, first pipe-only request acked normally.

Source files
------------

// File: rtl/stamofu_req_arbiter.sv
// Arbitrates stamofu pipeline and misaligned-queue requests into one registered slot toward dtlb/dcache.
// Define STAMOFU_REQ_ARBITER_STARVE_EN to add the pipe anti-starvation FSM; otherwise MQ always has priority.
module stamofu_req_arbiter #(
    parameter int unsigned STARVE_THRESHOLD       = 4,
    parameter int unsigned LOG_STAMOFU_MQ_ENTRIES = 3,
    parameter int unsigned VPN_WIDTH              = 20,
    parameter int unsigned PO_WIDTH               = 12,
    parameter int unsigned LOG_STAMOFU_CQ_ENTRIES = 5
) (
    input  logic                              CLK,
    input  logic                              nRST,

    input  logic                              pipe_REQ_valid,
    input  logic                              pipe_REQ_is_store,
    input  logic                              pipe_REQ_is_amo,
    input  logic                              pipe_REQ_is_fence,
    input  logic [3:0]                        pipe_REQ_op,
    input  logic                              pipe_REQ_is_mq,
    input  logic                              pipe_REQ_misaligned,
    input  logic                              pipe_REQ_misaligned_exception,
    input  logic [VPN_WIDTH-1:0]              pipe_REQ_VPN,
    input  logic [PO_WIDTH-3:0]               pipe_REQ_PO_word,
    input  logic [3:0]                        pipe_REQ_byte_mask,
    input  logic [31:0]                       pipe_REQ_write_data,
    input  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] pipe_REQ_cq_index,
    output logic                              pipe_REQ_ack,

    input  logic                              mq_REQ_valid,
    input  logic                              mq_REQ_is_store,
    input  logic                              mq_REQ_is_amo,
    input  logic                              mq_REQ_is_fence,
    input  logic [3:0]                        mq_REQ_op,
    input  logic                              mq_REQ_is_mq,
    input  logic                              mq_REQ_misaligned,
    input  logic                              mq_REQ_misaligned_exception,
    input  logic [VPN_WIDTH-1:0]              mq_REQ_VPN,
    input  logic [PO_WIDTH-3:0]               mq_REQ_PO_word,
    input  logic [3:0]                        mq_REQ_byte_mask,
    input  logic [31:0]                       mq_REQ_write_data,
    input  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] mq_REQ_cq_index,
    input  logic [LOG_STAMOFU_MQ_ENTRIES-1:0] mq_REQ_mq_index,
    output logic                              mq_REQ_ack,

    output logic                              out_valid,
    output logic                              out_is_store,
    output logic                              out_is_amo,
    output logic                              out_is_fence,
    output logic [3:0]                        out_op,
    output logic                              out_is_mq,
    output logic                              out_misaligned,
    output logic                              out_misaligned_exception,
    output logic [VPN_WIDTH-1:0]              out_VPN,
    output logic [PO_WIDTH-3:0]               out_PO_word,
    output logic [3:0]                        out_byte_mask,
    output logic [31:0]                       out_write_data,
    output logic [LOG_STAMOFU_CQ_ENTRIES-1:0] out_cq_index,
    output logic                              out_from_mq,
    output logic [LOG_STAMOFU_MQ_ENTRIES-1:0] out_mq_index,
    input  logic                              out_ready
);

    typedef struct packed {
        logic                              is_store;
        logic                              is_amo;
        logic                              is_fence;
        logic [3:0]                        op;
        logic                              is_mq;
        logic                              misaligned;
        logic                              misaligned_exception;
        logic [VPN_WIDTH-1:0]              vpn;
        logic [PO_WIDTH-3:0]               po_word;
        logic [3:0]                        byte_mask;
        logic [31:0]                       write_data;
        logic [LOG_STAMOFU_CQ_ENTRIES-1:0] cq_index;
    } req_t;

    generate
        if (STARVE_THRESHOLD < 1 || STARVE_THRESHOLD > 15) begin : g_thr_range_check
            $error("STARVE_THRESHOLD must be in 1..15");
        end
    endgenerate

    req_t                              pipe_req;
    req_t                              mq_req;
    req_t                              out_req_q;
    req_t                              out_req_d;
    logic                              out_valid_q;
    logic                              out_valid_d;
    logic                              out_from_mq_q;
    logic                              out_from_mq_d;
    logic [LOG_STAMOFU_MQ_ENTRIES-1:0] out_mq_index_q;
    logic [LOG_STAMOFU_MQ_ENTRIES-1:0] out_mq_index_d;

    logic free;
    logic grant_pipe;
    logic grant_mq;

    always_comb begin
        pipe_req.is_store             = pipe_REQ_is_store;
        pipe_req.is_amo               = pipe_REQ_is_amo;
        pipe_req.is_fence             = pipe_REQ_is_fence;
        pipe_req.op                   = pipe_REQ_op;
        pipe_req.is_mq                = pipe_REQ_is_mq;
        pipe_req.misaligned           = pipe_REQ_misaligned;
        pipe_req.misaligned_exception = pipe_REQ_misaligned_exception;
        pipe_req.vpn                  = pipe_REQ_VPN;
        pipe_req.po_word              = pipe_REQ_PO_word;
        pipe_req.byte_mask            = pipe_REQ_byte_mask;
        pipe_req.write_data           = pipe_REQ_write_data;
        pipe_req.cq_index             = pipe_REQ_cq_index;
    end

    always_comb begin
        mq_req.is_store             = mq_REQ_is_store;
        mq_req.is_amo               = mq_REQ_is_amo;
        mq_req.is_fence             = mq_REQ_is_fence;
        mq_req.op                   = mq_REQ_op;
        mq_req.is_mq                = mq_REQ_is_mq;
        mq_req.misaligned           = mq_REQ_misaligned;
        mq_req.misaligned_exception = mq_REQ_misaligned_exception;
        mq_req.vpn                  = mq_REQ_VPN;
        mq_req.po_word              = mq_REQ_PO_word;
        mq_req.byte_mask            = mq_REQ_byte_mask;
        mq_req.write_data           = mq_REQ_write_data;
        mq_req.cq_index             = mq_REQ_cq_index;
    end

    assign free = ~out_valid_q | out_ready;

    // Acks are gated by nRST so nothing is consumed while the slot is held in reset.
    assign pipe_REQ_ack = nRST & free & pipe_REQ_valid & grant_pipe;
    assign mq_REQ_ack   = nRST & free & mq_REQ_valid & grant_mq;

`ifdef STAMOFU_REQ_ARBITER_STARVE_EN
    // state       | meaning
    // ST_NORMAL   | MQ has priority over pipe; starve_cnt tracks consecutive pipe losses
    // ST_PIPE_FORCE | pipe wins whenever valid; MQ only wins if pipe is idle
    typedef enum logic [0:0] {
        ST_NORMAL     = 1'b0,
        ST_PIPE_FORCE = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_THR = 4'(STARVE_THRESHOLD);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        grant_pipe = 1'b0;
        grant_mq   = 1'b0;
        if (state_q == ST_PIPE_FORCE && pipe_REQ_valid) begin
            grant_pipe = 1'b1;
        end else if (mq_REQ_valid) begin
            grant_mq = 1'b1;
        end else if (pipe_REQ_valid) begin
            grant_pipe = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Backpressured cycles leave both the counter and the state untouched.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (free) begin
            if (!pipe_REQ_valid || pipe_REQ_ack) begin
                starve_cnt_d = 4'd0;
            end else if (mq_REQ_ack && starve_cnt_q != 4'hF) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
            case (state_q)
                ST_NORMAL: begin
                    if (starve_cnt_d >= STARVE_THR) begin
                        state_d = ST_PIPE_FORCE;
                    end
                end
                ST_PIPE_FORCE: begin
                    if (!pipe_REQ_valid || pipe_REQ_ack) begin
                        state_d      = ST_NORMAL;
                        starve_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d      = ST_NORMAL;
                    starve_cnt_d = 4'd0;
                end
            endcase
        end
    end
`else
    always_comb begin
        grant_pipe = 1'b0;
        grant_mq   = 1'b0;
        if (mq_REQ_valid) begin
            grant_mq = 1'b1;
        end else if (pipe_REQ_valid) begin
            grant_pipe = 1'b1;
        end
    end
`endif

    // A free slot with no winner drops out_valid but keeps the stale fields.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_req_d      = out_req_q;
        out_from_mq_d  = out_from_mq_q;
        out_mq_index_d = out_mq_index_q;
        if (free) begin
            out_valid_d = pipe_REQ_ack | mq_REQ_ack;
            if (mq_REQ_ack) begin
                out_req_d      = mq_req;
                out_from_mq_d  = 1'b1;
                out_mq_index_d = mq_REQ_mq_index;
            end else if (pipe_REQ_ack) begin
                out_req_d      = pipe_req;
                out_from_mq_d  = 1'b0;
                out_mq_index_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q         <= 1'b0;
            out_req_q           <= '0;
            out_req_q.byte_mask <= 4'b1111;
            out_from_mq_q       <= 1'b0;
            out_mq_index_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_req_q      <= out_req_d;
            out_from_mq_q  <= out_from_mq_d;
            out_mq_index_q <= out_mq_index_d;
        end
    end

    assign out_valid                = out_valid_q;
    assign out_is_store             = out_req_q.is_store;
    assign out_is_amo               = out_req_q.is_amo;
    assign out_is_fence             = out_req_q.is_fence;
    assign out_op                   = out_req_q.op;
    assign out_is_mq                = out_req_q.is_mq;
    assign out_misaligned           = out_req_q.misaligned;
    assign out_misaligned_exception = out_req_q.misaligned_exception;
    assign out_VPN                  = out_req_q.vpn;
    assign out_PO_word              = out_req_q.po_word;
    assign out_byte_mask            = out_req_q.byte_mask;
    assign out_write_data           = out_req_q.write_data;
    assign out_cq_index             = out_req_q.cq_index;
    assign out_from_mq              = out_from_mq_q;
    assign out_mq_index             = out_mq_index_q;

endmodule

// File: tb/tb_stamofu_req_arbiter.sv
// Self-checking bench for stamofu_req_arbiter: vector table plus hand-written starvation,
// backpressure and mid-operation reset sequences, with an expected-output queue.
module tb_stamofu_req_arbiter;

    typedef logic [84:0] bund_t;

    typedef struct {
        bit         pv;
        bit         mv;
        bit         rdy;
        logic [4:0] cq;
        logic [19:0] vpn;
        logic [2:0] mqi;
        bit         pa;
        bit         ma;
    } vec_t;

`ifdef STAMOFU_REQ_ARBITER_STARVE_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    localparam bund_t RESET_B = {1'b0, 3'b0, 3'b0, 4'b0, 3'b0, 20'b0, 10'b0, 4'b1111, 32'b0, 5'b0};

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        pipe_REQ_valid, pipe_REQ_is_store, pipe_REQ_is_amo, pipe_REQ_is_fence;
    logic [3:0]  pipe_REQ_op;
    logic        pipe_REQ_is_mq, pipe_REQ_misaligned, pipe_REQ_misaligned_exception;
    logic [19:0] pipe_REQ_VPN;
    logic [9:0]  pipe_REQ_PO_word;
    logic [3:0]  pipe_REQ_byte_mask;
    logic [31:0] pipe_REQ_write_data;
    logic [4:0]  pipe_REQ_cq_index;
    logic        pipe_REQ_ack;

    logic        mq_REQ_valid, mq_REQ_is_store, mq_REQ_is_amo, mq_REQ_is_fence;
    logic [3:0]  mq_REQ_op;
    logic        mq_REQ_is_mq, mq_REQ_misaligned, mq_REQ_misaligned_exception;
    logic [19:0] mq_REQ_VPN;
    logic [9:0]  mq_REQ_PO_word;
    logic [3:0]  mq_REQ_byte_mask;
    logic [31:0] mq_REQ_write_data;
    logic [4:0]  mq_REQ_cq_index;
    logic [2:0]  mq_REQ_mq_index;
    logic        mq_REQ_ack;

    logic        out_valid, out_is_store, out_is_amo, out_is_fence;
    logic [3:0]  out_op;
    logic        out_is_mq, out_misaligned, out_misaligned_exception;
    logic [19:0] out_VPN;
    logic [9:0]  out_PO_word;
    logic [3:0]  out_byte_mask;
    logic [31:0] out_write_data;
    logic [4:0]  out_cq_index;
    logic        out_from_mq;
    logic [2:0]  out_mq_index;
    logic        out_ready;

    stamofu_req_arbiter #(
        .STARVE_THRESHOLD      (4),
        .LOG_STAMOFU_MQ_ENTRIES(3),
        .VPN_WIDTH             (20),
        .PO_WIDTH              (12),
        .LOG_STAMOFU_CQ_ENTRIES(5)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_REQ_valid(pipe_REQ_valid), .pipe_REQ_is_store(pipe_REQ_is_store),
        .pipe_REQ_is_amo(pipe_REQ_is_amo), .pipe_REQ_is_fence(pipe_REQ_is_fence),
        .pipe_REQ_op(pipe_REQ_op), .pipe_REQ_is_mq(pipe_REQ_is_mq),
        .pipe_REQ_misaligned(pipe_REQ_misaligned),
        .pipe_REQ_misaligned_exception(pipe_REQ_misaligned_exception),
        .pipe_REQ_VPN(pipe_REQ_VPN), .pipe_REQ_PO_word(pipe_REQ_PO_word),
        .pipe_REQ_byte_mask(pipe_REQ_byte_mask), .pipe_REQ_write_data(pipe_REQ_write_data),
        .pipe_REQ_cq_index(pipe_REQ_cq_index), .pipe_REQ_ack(pipe_REQ_ack),
        .mq_REQ_valid(mq_REQ_valid), .mq_REQ_is_store(mq_REQ_is_store),
        .mq_REQ_is_amo(mq_REQ_is_amo), .mq_REQ_is_fence(mq_REQ_is_fence),
        .mq_REQ_op(mq_REQ_op), .mq_REQ_is_mq(mq_REQ_is_mq),
        .mq_REQ_misaligned(mq_REQ_misaligned),
        .mq_REQ_misaligned_exception(mq_REQ_misaligned_exception),
        .mq_REQ_VPN(mq_REQ_VPN), .mq_REQ_PO_word(mq_REQ_PO_word),
        .mq_REQ_byte_mask(mq_REQ_byte_mask), .mq_REQ_write_data(mq_REQ_write_data),
        .mq_REQ_cq_index(mq_REQ_cq_index), .mq_REQ_mq_index(mq_REQ_mq_index),
        .mq_REQ_ack(mq_REQ_ack),
        .out_valid(out_valid), .out_is_store(out_is_store), .out_is_amo(out_is_amo),
        .out_is_fence(out_is_fence), .out_op(out_op), .out_is_mq(out_is_mq),
        .out_misaligned(out_misaligned), .out_misaligned_exception(out_misaligned_exception),
        .out_VPN(out_VPN), .out_PO_word(out_PO_word), .out_byte_mask(out_byte_mask),
        .out_write_data(out_write_data), .out_cq_index(out_cq_index),
        .out_from_mq(out_from_mq), .out_mq_index(out_mq_index), .out_ready(out_ready)
    );

    bund_t dut_b;
    assign dut_b = {out_from_mq, out_mq_index, out_is_store, out_is_amo, out_is_fence, out_op,
                    out_is_mq, out_misaligned, out_misaligned_exception, out_VPN, out_PO_word,
                    out_byte_mask, out_write_data, out_cq_index};

    int    passed = 0;
    int    total = 0;
    bit    exp_valid;
    bund_t last_exp;
    bund_t exp_q[$];

    function automatic vec_t mk(bit pv, bit mv, bit rdy, logic [4:0] cq, logic [19:0] vpn,
                                logic [2:0] mqi, bit pa, bit ma);
        vec_t v;
        v.pv = pv; v.mv = mv; v.rdy = rdy; v.cq = cq; v.vpn = vpn; v.mqi = mqi;
        v.pa = pa; v.ma = ma;
        return v;
    endfunction

    function automatic bund_t pipe_bund(vec_t v);
        return {1'b0, 3'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, v.vpn, v.vpn[9:0],
                4'b0011, {12'hABC, v.vpn}, v.cq};
    endfunction

    function automatic bund_t mq_bund(vec_t v);
        logic [19:0] nv;
        logic [4:0]  cq1;
        nv  = ~v.vpn;
        cq1 = v.cq + 5'd1;
        return {1'b1, v.mqi, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, nv, nv[9:0],
                4'b1100, {12'h5A5, nv}, cq1};
    endfunction

    task automatic chk(input string nm, input bund_t act, input bund_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        logic [19:0] nv;
        nv = ~v.vpn;
        pipe_REQ_valid = v.pv;
        pipe_REQ_is_store = 1'b1; pipe_REQ_is_amo = 1'b0; pipe_REQ_is_fence = 1'b0;
        pipe_REQ_op = 4'h3; pipe_REQ_is_mq = 1'b0; pipe_REQ_misaligned = 1'b0;
        pipe_REQ_misaligned_exception = 1'b0;
        pipe_REQ_VPN = v.vpn; pipe_REQ_PO_word = v.vpn[9:0]; pipe_REQ_byte_mask = 4'b0011;
        pipe_REQ_write_data = {12'hABC, v.vpn}; pipe_REQ_cq_index = v.cq;
        mq_REQ_valid = v.mv;
        mq_REQ_is_store = 1'b0; mq_REQ_is_amo = 1'b1; mq_REQ_is_fence = 1'b1;
        mq_REQ_op = 4'hA; mq_REQ_is_mq = 1'b1; mq_REQ_misaligned = 1'b1;
        mq_REQ_misaligned_exception = 1'b1;
        mq_REQ_VPN = nv; mq_REQ_PO_word = nv[9:0]; mq_REQ_byte_mask = 4'b1100;
        mq_REQ_write_data = {12'h5A5, nv}; mq_REQ_cq_index = v.cq + 5'd1;
        mq_REQ_mq_index = v.mqi;
        out_ready = v.rdy;
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic step(input vec_t v, input string tag);
        bit free_m;
        drive(v);
        @(negedge CLK);
        chk({tag, " pipe_ack"}, {84'b0, pipe_REQ_ack}, {84'b0, v.pa});
        chk({tag, " mq_ack"}, {84'b0, mq_REQ_ack}, {84'b0, v.ma});
        free_m = !exp_valid || v.rdy;
        if (v.pa) exp_q.push_back(pipe_bund(v));
        else if (v.ma) exp_q.push_back(mq_bund(v));
        @(posedge CLK);
        #1;
        if (v.pa || v.ma) begin
            exp_valid = 1'b1;
            if (exp_q.size() == 0) chk({tag, " queue_empty"}, 85'd1, 85'd0);
            else last_exp = exp_q.pop_front();
        end else if (free_m) begin
            exp_valid = 1'b0;
        end
        chk({tag, " out_valid"}, {84'b0, out_valid}, {84'b0, exp_valid});
        chk({tag, " out_fields"}, dut_b, last_exp);
    endtask

    vec_t tbl[13];
    vec_t seq[$];

    initial begin
        nRST = 1'b0;
        drive(mk(1, 1, 1, 5'd9, 20'hAAAAA, 3'd1, 0, 0));
        exp_valid = 1'b0;
        last_exp  = RESET_B;

        tbl[0]  = mk(1, 0, 1, 5'd5,  20'h12345, 3'd0, 1, 0);
        tbl[1]  = mk(1, 1, 1, 5'd6,  20'h0F0F0, 3'd2, 0, 1);
        tbl[2]  = mk(0, 0, 1, 5'd7,  20'h11111, 3'd3, 0, 0);
        tbl[3]  = mk(0, 1, 1, 5'd8,  20'h22222, 3'd7, 0, 1);
        tbl[4]  = mk(1, 1, 0, 5'd9,  20'h33333, 3'd1, 0, 0);
        tbl[5]  = mk(1, 1, 0, 5'd10, 20'h44444, 3'd5, 0, 0);
        tbl[6]  = mk(1, 1, 0, 5'd11, 20'h55555, 3'd6, 0, 0);
        tbl[7]  = mk(1, 1, 1, 5'd12, 20'h66666, 3'd4, 0, 1);
        tbl[8]  = mk(1, 0, 1, 5'd31, 20'hFFFFF, 3'd0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 5'd1,  20'h77777, 3'd2, 0, 0);
        tbl[10] = mk(0, 0, 1, 5'd2,  20'h88888, 3'd2, 0, 0);
        tbl[11] = mk(1, 0, 0, 5'd3,  20'h99999, 3'd2, 1, 0);
        tbl[12] = mk(0, 0, 1, 5'd4,  20'hABCDE, 3'd2, 0, 0);

        #12;
        chk("reset out_valid", {84'b0, out_valid}, 85'd0);
        chk("reset out_fields", dut_b, RESET_B);
        chk("reset pipe_ack", {84'b0, pipe_REQ_ack}, 85'd0);
        chk("reset mq_ack", {84'b0, mq_REQ_ack}, 85'd0);
        drive(mk(0, 0, 1, 5'd0, 20'h0, 3'd0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Sustained contention: pipe forced through after four MQ wins when starvation control is on.
        for (int i = 0; i < 4; i++) seq.push_back(mk(1, 1, 1, 5'(i), 20'(32'h10000 + i), 3'(i), 0, 1));
        seq.push_back(mk(1, 1, 1, 5'd20, 20'h2F00D, 3'd5, SE, !SE));
        seq.push_back(mk(1, 1, 1, 5'd21, 20'h3BEEF, 3'd6, 0, 1));
        seq.push_back(mk(0, 0, 1, 5'd22, 20'h00001, 3'd0, 0, 0));
        for (int i = 0; i < 4; i++) seq.push_back(mk(1, 1, 1, 5'(i + 8), 20'(32'h40000 + i), 3'(i + 1), 0, 1));
        seq.push_back(mk(0, 1, 1, 5'd23, 20'h5CAFE, 3'd7, 0, 1));
        seq.push_back(mk(1, 1, 1, 5'd24, 20'h6D00D, 3'd3, 0, 1));
        seq.push_back(mk(0, 0, 1, 5'd25, 20'h00002, 3'd0, 0, 0));
        foreach (seq[i]) step(seq[i], $sformatf("starve%0d", i));
        seq.delete();

        // Backpressure must freeze the starvation count at 3 so the next grant is MQ, then pipe.
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 1, 1, 5'(i + 12), 20'(32'h70000 + i), 3'(i + 2), 0, 1));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 1, 0, 5'(i + 16), 20'(32'h80000 + i), 3'(i), 0, 0));
        seq.push_back(mk(1, 1, 1, 5'd26, 20'h9ABCD, 3'd4, 0, 1));
        seq.push_back(mk(1, 1, 1, 5'd27, 20'hA1234, 3'd6, SE, !SE));
        seq.push_back(mk(0, 0, 1, 5'd28, 20'h00003, 3'd0, 0, 0));
        foreach (seq[i]) step(seq[i], $sformatf("bp%0d", i));
        seq.delete();

        for (int i = 0; i < 3; i++) step(mk(1, 1, 1, 5'(i + 1), 20'(32'hB0000 + i), 3'(i + 1), 0, 1),
                                         $sformatf("pre_rst%0d", i));
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst out_valid", {84'b0, out_valid}, 85'd0);
        chk("midrst out_fields", dut_b, RESET_B);
        chk("midrst pipe_ack", {84'b0, pipe_REQ_ack}, 85'd0);
        chk("midrst mq_ack", {84'b0, mq_REQ_ack}, 85'd0);
        drive(mk(0, 0, 1, 5'd0, 20'h0, 3'd0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        exp_valid = 1'b0;
        last_exp  = RESET_B;
        exp_q.delete();
        step(mk(0, 0, 1, 5'd0, 20'h0, 3'd0, 0, 0), "post_rst_idle");
        step(mk(1, 0, 1, 5'd13, 20'hC0FFE, 3'd0, 1, 0), "post_rst_pipe");
        step(mk(0, 0, 1, 5'd0, 20'h0, 3'd0, 0, 0), "post_rst_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
